alu_op_issue: RTL and testbench
===============================

Name: alu_op_issue

Overview:
- Producer end of the ALU operand/control interface.
- Accepts one RV32 instruction plus register-file read data per valid/ready handshake, decodes `alu_control`, and selects and sign-extends operands.
- Presents the registered result on a second valid/ready handshake, with a 2-entry skid buffer, to the combinational ALU in the execute stage.
- Unsupported encodings pass through flagged illegal and are never dropped.

Parameters:
- XLEN, 32, datapath width of `rs1_data`, `rs2_data`, `alu_in1` and `alu_in2`. Only 32 is supported.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  block can accept
- instr  in  32  RV32 instruction word
- rs1_data  in  XLEN  rs1 register value
- rs2_data  in  XLEN  rs2 register value
- out_valid  out  1  decoded op valid
- out_ready  in  1  downstream (ALU stage) accepts
- alu_in1  out  XLEN  ALU operand 1
- alu_in2  out  XLEN  ALU operand 2
- alu_control  out  4  ALU op code
- illegal  out  1  op not supported by the ALU

Behaviour:
- alu_control encoding (shared constants): AND=0000, OR=0001, ADD=0010, SUB=0100, SLTU=1000, SLL=0011, SRL=0101, MUL=0110, XOR=0111. The ALU's less-than compare is unsigned.
- Decode, opcode 0110011 (R-type):
  - funct7 0000000: funct3 000 ADD, 001 SLL, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7 0100000 with funct3 000: SUB.
  - funct7 0000001 with funct3 000: MUL.
  - Operands: in1=rs1_data, in2=rs2_data.
- Decode, opcode 0010011 (I-type):
  - ADDI, SLTIU, XORI, ORI, ANDI: in2 = sign-extended instr[31:20].
  - SLLI, SRLI: require instr[31:25]=0; in2 = zero-extended instr[24:20].
  - in1=rs1_data.
- Decode, opcode 0000011 (load): ADD, in1=rs1_data, in2 = sign-extended instr[31:20].
- Decode, opcode 0100011 (store): ADD, in1=rs1_data, in2 = sign-extended {instr[31:25],instr[11:7]}.
- Decode, opcode 1100011 with funct3 000/001 (BEQ/BNE): SUB, in1=rs1_data, in2=rs2_data.
- Decode, opcode 0110111 (LUI): ADD, in1=0, in2={instr[31:12],12'b0}.
- Everything else is illegal, including SLT, SLTI, SRA, SRAI and the other branches: illegal=1, alu_control=0010, in1=in2=0.
- Decode is combinational on the input side; the result is captured in the main register on accept (in_valid & in_ready).
- Latency is 1 cycle from accept to out_valid when the output is idle.
- Handshake states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main register valid, in_ready=1.
  - FULL: main and skid registers valid, in_ready=0.
- Transitions:
  - EMPTY+accept -> ONE.
  - ONE+accept+out_ready -> ONE; the main register is loaded with the new op.
  - ONE+accept+!out_ready -> FULL; the new op goes to the skid register.
  - ONE+!accept+out_ready -> EMPTY.
  - FULL+out_ready -> ONE; the skid register moves to main.
- in_ready is a registered function of state and never combinational on out_ready.
- Output fields are stable while out_valid=1 and out_ready=0.
- Order is strictly preserved, with no drop or duplication.
- Reset (async, any time including mid-transfer): state=EMPTY, out_valid=0, in_ready=1 after reset release, alu_in1=alu_in2=0, alu_control=0000, illegal=0. Skid contents are discarded.
- in_ready is 0 while rst_n=0.

Optional Feature:
- ALU_OP_ISSUE_MUL_EN:
  - Defined: MUL decodes to 0110.
  - Undefined: MUL (funct7 0000001, funct3 000) is illegal, and the other funct7=0000001 encodings stay illegal either way.

Decomposition:
- Package `alu_pkg`:
  - 4-bit alu_control localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_MUL, ALU_XOR.
  - RV32 opcode constants.
  - Packed struct `alu_req_t` {in1, in2, ctrl, illegal}.
- Sub-module `alu_op_decode` is purely combinational: instr/rs1/rs2 to alu_req_t.
- The top level holds the skid-buffer state machine.

Test Plan:
- ADDI 0xFFD10093, rs1_data=5, out_ready=1:
  - one cycle later out_valid=1, alu_in1=5, alu_in2=0xFFFFFFFD, alu_control=0010, illegal=0.
- SUB 0x402081B3, rs1=9, rs2=4:
  - alu_control=0100, alu_in1=9, alu_in2=4.
  - Then SRAI 0x40315093: illegal=1, ctrl=0010, operands 0.
- MUL 0x022081B3:
  - alu_control=0110 with ALU_OP_ISSUE_MUL_EN defined.
  - illegal=1 without it.
- Hold out_ready=0 and issue 3 back-to-back ops:
  - first two accepted, in_ready=0 after the second, third held.
  - Outputs stable; release delivers ops 1, 2, 3 in order, one per cycle.
- Random in_valid/out_ready over 1000 ops:
  - scoreboard checks no loss, duplication or reorder, and in_ready=0 only in FULL.
- Assert rst_n=0 while FULL:
  - outputs immediately (asynchronously) out_valid=0, alu_control=0000, in1=in2=0.
  - After release in_ready=1 and no stale op appears.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU control codes, RV32 opcodes and the request record
//               passed from the operand decoder to the issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_XLEN = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_MUL  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef struct packed {
        logic [ALU_XLEN-1:0] in1;
        logic [ALU_XLEN-1:0] in2;
        logic [3:0]          ctrl;
        logic                illegal;
    } alu_req_t;

    function automatic logic [ALU_XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(ALU_XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational RV32 decode of one instruction into ALU operands
//               and control. Macro ALU_OP_ISSUE_MUL_EN enables MUL decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0]         instr,
    input  logic [ALU_XLEN-1:0] rs1_data,
    input  logic [ALU_XLEN-1:0] rs2_data,
    output alu_req_t            req
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];

    always_comb begin
        // Illegal is the default; every supported path clears it explicitly.
        req.in1     = '0;
        req.in2     = '0;
        req.ctrl    = ALU_ADD;
        req.illegal = 1'b1;

        case (w_opcode)
            OPC_RTYPE: begin
                if (w_funct7 == 7'b0000000) begin
                    req.illegal = 1'b0;
                    case (w_funct3)
                        3'b000:  req.ctrl = ALU_ADD;
                        3'b001:  req.ctrl = ALU_SLL;
                        3'b011:  req.ctrl = ALU_SLTU;
                        3'b100:  req.ctrl = ALU_XOR;
                        3'b101:  req.ctrl = ALU_SRL;
                        3'b110:  req.ctrl = ALU_OR;
                        3'b111:  req.ctrl = ALU_AND;
                        default: req.illegal = 1'b1;
                    endcase
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
                    req.illegal = 1'b0;
                    req.ctrl    = ALU_SUB;
                end
`ifdef ALU_OP_ISSUE_MUL_EN
                else if (w_funct7 == 7'b0000001 && w_funct3 == 3'b000) begin
                    req.illegal = 1'b0;
                    req.ctrl    = ALU_MUL;
                end
`endif
                if (!req.illegal) begin
                    req.in1 = rs1_data;
                    req.in2 = rs2_data;
                end else begin
                    req.ctrl = ALU_ADD;
                end
            end

            OPC_ITYPE: begin
                req.illegal = 1'b0;
                req.in2     = sext12(instr[31:20]);
                case (w_funct3)
                    3'b000:  req.ctrl = ALU_ADD;
                    3'b011:  req.ctrl = ALU_SLTU;
                    3'b100:  req.ctrl = ALU_XOR;
                    3'b110:  req.ctrl = ALU_OR;
                    3'b111:  req.ctrl = ALU_AND;
                    3'b001: begin
                        req.ctrl    = ALU_SLL;
                        req.in2     = {{(ALU_XLEN-5){1'b0}}, instr[24:20]};
                        req.illegal = (w_funct7 != 7'b0000000);
                    end
                    3'b101: begin
                        req.ctrl    = ALU_SRL;
                        req.in2     = {{(ALU_XLEN-5){1'b0}}, instr[24:20]};
                        req.illegal = (w_funct7 != 7'b0000000);
                    end
                    default: req.illegal = 1'b1;
                endcase
                if (!req.illegal) begin
                    req.in1 = rs1_data;
                end else begin
                    req.ctrl = ALU_ADD;
                    req.in2  = '0;
                end
            end

            OPC_LOAD: begin
                req.illegal = 1'b0;
                req.in1     = rs1_data;
                req.in2     = sext12(instr[31:20]);
            end

            OPC_STORE: begin
                req.illegal = 1'b0;
                req.in1     = rs1_data;
                req.in2     = sext12({instr[31:25], instr[11:7]});
            end

            OPC_BRANCH: begin
                if (w_funct3 == 3'b000 || w_funct3 == 3'b001) begin
                    req.illegal = 1'b0;
                    req.ctrl    = ALU_SUB;
                    req.in1     = rs1_data;
                    req.in2     = rs2_data;
                end
            end

            OPC_LUI: begin
                req.illegal = 1'b0;
                req.in2     = {instr[31:12], 12'b0};
            end

            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_op_issue.sv
// ============================================================================
// Module      : alu_op_issue
// Description : Decodes instructions into ALU requests and issues them through
//               a 2-entry skid buffer. Macro ALU_OP_ISSUE_MUL_EN enables MUL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_control,
    output logic            illegal
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0] r_state;
    alu_req_t   r_main;
    alu_req_t   r_skid;
    alu_req_t   w_req;
    logic       w_accept;

    alu_op_decode u_decode (
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .req      (w_req)
    );

    // Ready depends only on the state register; rst_n gating holds it low in reset.
    assign in_ready  = rst_n && (r_state != ST_FULL);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state != ST_EMPTY);

    assign alu_in1     = r_main.in1;
    assign alu_in2     = r_main.in2;
    assign alu_control = r_main.ctrl;
    assign illegal     = r_main.illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= w_req;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && out_ready) begin
                        r_main <= w_req;
                    end else if (w_accept) begin
                        r_skid  <= w_req;
                        r_state <= ST_FULL;
                    end else if (out_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_issue.sv
// ============================================================================
// Module      : tb_alu_op_issue
// Description : Directed and randomised self-checking bench for alu_op_issue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_issue;

    localparam logic [31:0] I_ADD = 32'h002081B3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_control;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_op_issue #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_control (alu_control),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [3:0] ec, input logic ei);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_in1"}, alu_in1, e1);
        chk({tag, "_in2"}, alu_in2, e2);
        chk({tag, "_ctrl"}, 32'(alu_control), 32'(ec));
        chk({tag, "_ill"}, 32'(illegal), 32'(ei));
    endtask

    // Present one op for one cycle with out_ready high, then check it and idle.
    task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        @(negedge clk);
        instr = ins; rs1_data = r1; rs2_data = r2; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin : main
        logic [68:0] q[$];
        logic [68:0] exp_e;
        int cnt, pushed, cyc;
        logic ofire, ifire;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs1_data = '0; rs2_data = '0;
        #2;
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ctrl", 32'(alu_control), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // ADDI x1, x2, -3
        issue(32'hFFD10093, 32'd5, 32'd0);
        chk_out("addi", 32'd5, 32'hFFFFFFFD, 4'b0010, 1'b0);
        issue(32'h402081B3, 32'd9, 32'd4);
        chk_out("sub", 32'd9, 32'd4, 4'b0100, 1'b0);
        issue(32'h40315093, 32'd7, 32'd8);
        chk_out("srai", 32'd0, 32'd0, 4'b0010, 1'b1);
        issue(32'h022081B3, 32'd6, 32'd7);
`ifdef ALU_OP_ISSUE_MUL_EN
        chk_out("mul", 32'd6, 32'd7, 4'b0110, 1'b0);
`else
        chk_out("mul", 32'd0, 32'd0, 4'b0010, 1'b1);
`endif
        issue(32'h12345037, 32'd3, 32'd3);
        chk_out("lui", 32'd0, 32'h12345000, 4'b0010, 1'b0);
        issue(32'hFE20AE23, 32'h100, 32'd1);
        chk_out("sw", 32'h100, 32'hFFFFFFFC, 4'b0010, 1'b0);
        issue(32'h00208063, 32'd10, 32'd11);
        chk_out("beq", 32'd10, 32'd11, 4'b0100, 1'b0);
        issue(32'h00309093, 32'hF0, 32'd0);
        chk_out("slli", 32'hF0, 32'd3, 4'b0011, 1'b0);
        issue(32'h0020A1B3, 32'd1, 32'd2);
        chk_out("slt", 32'd0, 32'd0, 4'b0010, 1'b1);
        @(negedge clk);
        chk("idle_empty", 32'(out_valid), 32'd0);

        // Back-pressure: fill to FULL, hold a third op, then drain in order.
        out_ready = 1'b0;
        instr = I_ADD; rs1_data = 32'h11; rs2_data = 32'h12; in_valid = 1'b1;
        @(negedge clk);
        chk("bp1_in_ready", 32'(in_ready), 32'd1);
        chk_out("bp1", 32'h11, 32'h12, 4'b0010, 1'b0);
        rs1_data = 32'h21; rs2_data = 32'h22;
        @(negedge clk);
        chk("bp2_in_ready", 32'(in_ready), 32'd0);
        chk_out("bp2", 32'h11, 32'h12, 4'b0010, 1'b0);
        rs1_data = 32'h31; rs2_data = 32'h32;
        @(negedge clk);
        chk("bp3_in_ready", 32'(in_ready), 32'd0);
        chk_out("bp3_hold", 32'h11, 32'h12, 4'b0010, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk_out("drain2", 32'h21, 32'h22, 4'b0010, 1'b0);
        chk("drain2_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("drain3", 32'h31, 32'h32, 4'b0010, 1'b0);
        @(negedge clk);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset while FULL.
        out_ready = 1'b0; in_valid = 1'b1;
        rs1_data = 32'hAA; rs2_data = 32'hBB;
        @(negedge clk);
        rs1_data = 32'hCC; rs2_data = 32'hDD;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_before_rst", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ctrl", 32'(alu_control), 32'd0);
        chk("arst_in1", alu_in1, 32'd0);
        chk("arst_in2", alu_in2, 32'd0);
        chk("arst_ill", 32'(illegal), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        chk("arst_rel_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
        end

        // Random traffic with a scoreboard and an occupancy model.
        cnt = 0; pushed = 0; cyc = 0;
        instr = I_ADD;
        while ((pushed < 1000 || q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            chk("rnd_in_ready", 32'(in_ready), 32'(cnt != 2));
            chk("rnd_out_valid", 32'(out_valid), 32'(cnt != 0));
            out_ready = ($urandom_range(0, 3) != 0);
            if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1; rs1_data = $urandom; rs2_data = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            ofire = out_valid && out_ready;
            ifire = in_valid && in_ready;
            if (ofire) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 32'd1, 32'd0);
                end else begin
                    exp_e = q.pop_front();
                    chk("rnd_in1", alu_in1, exp_e[68:37]);
                    chk("rnd_in2", alu_in2, exp_e[36:5]);
                    chk("rnd_ctrl", 32'(alu_control), 32'(exp_e[4:1]));
                    chk("rnd_ill", 32'(illegal), 32'(exp_e[0]));
                end
            end
            if (ifire) begin
                q.push_back({rs1_data, rs2_data, 4'b0010, 1'b0});
                pushed++;
            end
            cnt = cnt + int'(ifire) - int'(ofire);
        end
        chk("rnd_timeout", 32'(cyc < 20000), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rnd_final_empty", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
